// File: rtl/wb_burst_master_pkg.sv
// Shared types and constants for the Wishbone burst master: FSM state encoding,
// cycle-type identifiers and the per-beat CTI selection helper.
package wb_master_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        BURST     = 2'd2,
        ABORT     = 2'd3
    } wbm_state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // A lone beat is a classic cycle; otherwise the final beat closes the burst.
    function automatic logic [2:0] beat_cti(input logic [2:0] idx, input logic [2:0] len);
        if (len == 3'd0) return CTI_CLASSIC;
        if (idx == len)  return CTI_EOB;
        return CTI_INCR;
    endfunction

endpackage

// File: rtl/wb_burst_master_if.sv
// Wishbone bus between the burst master and the memory controller slave port.
interface wb_burst_master_if #(
    parameter int dw     = 32,
    parameter int APP_AW = 26
) ();

    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [APP_AW-1:0] wb_addr_o;
    logic [dw-1:0]     wb_dat_o;
    logic [dw/8-1:0]   wb_sel_o;
    logic [2:0]        wb_cti_o;
    logic              wb_ack_i;
    logic [dw-1:0]     wb_dat_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
        input  wb_ack_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
        output wb_ack_i, wb_dat_i
    );

endinterface

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with occupancy count; pop_n may discard several
// entries in one cycle so an aborted burst can drop its leftover beats at once.
module sync_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic [CW-1:0]    pop_n,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;

    function automatic logic [PW-1:0] ptr_adv(input logic [PW-1:0] p, input logic [CW-1:0] n);
        logic [CW:0] s;
        s = (CW+1)'(p) + (CW+1)'(n);
        if (s >= (CW+1)'(DEPTH)) s = s - (CW+1)'(DEPTH);
        return s[PW-1:0];
    endfunction

    assign push_ok = push && !full;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_adv(wr_ptr, CW'(1));
            rd_ptr <= ptr_adv(rd_ptr, pop_n);
            count  <= count + CW'(push_ok) - pop_n;
        end
    end

endmodule

// File: rtl/wb_burst_master.sv
// Turns command transactions into Wishbone incrementing bursts, buffering write
// data so a write burst never stalls and streaming read data back out.
module wb_burst_master
    import wb_master_pkg::*;
#(
    parameter int dw      = 32,
    parameter int APP_AW  = 26,
    parameter int MAX_BL  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    // cmd_* and wr_* transfer on a rising edge where valid && ready are both
    // high; rd_* is a pure valid stream with no backpressure.
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [APP_AW-1:0] cmd_addr,
    input  logic [2:0]        cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [dw-1:0]     wr_data,
    input  logic [dw/8-1:0]   wr_sel,
    output logic              rd_valid,
    output logic [dw-1:0]     rd_data,
    output logic              rd_last,
    output logic              done,
    output logic              err,
    output logic              busy,
    output wbm_state_t        state_dbg,
    wb_burst_master_if.master wb
);

    localparam int CW = $clog2(MAX_BL + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    wbm_state_t          state;
    logic                is_we;
    logic [2:0]          len_q;
    logic [2:0]          beat_q;
    logic [TW-1:0]       to_cnt;

    logic [dw+dw/8-1:0]  fifo_rdata;
    logic [CW-1:0]       fifo_count;
    logic [CW-1:0]       fifo_pop_n;
    logic [CW-1:0]       remaining;
    logic                fifo_full;
    logic                fifo_empty;

    sync_fifo #(
        .WIDTH (dw + dw/8),
        .DEPTH (MAX_BL)
    ) u_wr_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (wr_valid),
        .wdata ({wr_sel, wr_data}),
        .pop_n (fifo_pop_n),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign cmd_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign state_dbg   = state;
    assign wr_ready    = !fifo_full;
    assign wb.wb_dat_o = fifo_rdata[dw-1:0];
    assign wb.wb_sel_o = fifo_rdata[dw +: dw/8];
    assign remaining   = CW'(len_q) - CW'(beat_q) + CW'(1);

    // An aborted write discards the beats it never delivered so the next
    // command starts from its own data.
    always_comb begin
        fifo_pop_n = '0;
        if (wb.wb_cyc_o && wb.wb_we_o && wb.wb_ack_i && !fifo_empty)
            fifo_pop_n = CW'(1);
        else if (state == ABORT && is_we)
            fifo_pop_n = remaining;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            is_we        <= 1'b0;
            len_q        <= '0;
            beat_q       <= '0;
            to_cnt       <= '0;
            wb.wb_cyc_o  <= 1'b0;
            wb.wb_stb_o  <= 1'b0;
            wb.wb_we_o   <= 1'b0;
            wb.wb_addr_o <= '0;
            wb.wb_cti_o  <= CTI_CLASSIC;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            rd_last      <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        is_we        <= cmd_we;
                        len_q        <= cmd_len;
                        beat_q       <= '0;
                        wb.wb_addr_o <= cmd_addr;
                        if (cmd_we) begin
                            state <= WAIT_DATA;
                        end else begin
                            state       <= BURST;
                            wb.wb_cyc_o <= 1'b1;
                            wb.wb_stb_o <= 1'b1;
                            wb.wb_we_o  <= 1'b0;
                            wb.wb_cti_o <= beat_cti(3'd0, cmd_len);
                            to_cnt      <= '0;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (fifo_count >= CW'(len_q) + CW'(1)) begin
                        state       <= BURST;
                        wb.wb_cyc_o <= 1'b1;
                        wb.wb_stb_o <= 1'b1;
                        wb.wb_we_o  <= 1'b1;
                        wb.wb_cti_o <= beat_cti(3'd0, len_q);
                        to_cnt      <= '0;
                    end
                end
                BURST: begin
                    if (wb.wb_ack_i) begin
                        to_cnt       <= '0;
                        beat_q       <= beat_q + 3'd1;
                        wb.wb_addr_o <= wb.wb_addr_o + APP_AW'(dw / 8);
                        if (!is_we) begin
                            rd_valid <= 1'b1;
                            rd_data  <= wb.wb_dat_i;
                        end
                        if (beat_q == len_q) begin
                            state       <= IDLE;
                            wb.wb_cyc_o <= 1'b0;
                            wb.wb_stb_o <= 1'b0;
                            wb.wb_we_o  <= 1'b0;
                            wb.wb_cti_o <= CTI_CLASSIC;
                            done        <= 1'b1;
                            rd_last     <= !is_we;
                        end else begin
                            wb.wb_cti_o <= beat_cti(beat_q + 3'd1, len_q);
                        end
                    end else if (to_cnt == TW'(TIMEOUT)) begin
                        state       <= ABORT;
                        wb.wb_cyc_o <= 1'b0;
                        wb.wb_stb_o <= 1'b0;
                        wb.wb_we_o  <= 1'b0;
                        wb.wb_cti_o <= CTI_CLASSIC;
                        err         <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                ABORT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: Wishbone slave memory model, bus and read-stream
// scoreboards, a table of bursts and hand-written corner-case sequences.
module tb_wb_burst_master;
    import wb_master_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 26;
    localparam int TMO = 15;
    localparam int BW  = 66;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            cmd_we = 1'b0;
    logic [AW-1:0]   cmd_addr = '0;
    logic [2:0]      cmd_len = '0;
    logic            wr_valid = 1'b0;
    logic            wr_ready;
    logic [DW-1:0]   wr_data = '0;
    logic [DW/8-1:0] wr_sel = '0;
    logic            rd_valid;
    logic [DW-1:0]   rd_data;
    logic            rd_last;
    logic            done;
    logic            err;
    logic            busy;
    wbm_state_t      state_dbg;

    wb_burst_master_if #(.dw(DW), .APP_AW(AW)) wb_bus ();

    wb_burst_master #(
        .dw(DW), .APP_AW(AW), .MAX_BL(8), .TIMEOUT(TMO)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .wr_sel   (wr_sel),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .state_dbg(state_dbg),
        .wb       (wb_bus)
    );

    // ---------------- clock / reset ----------------
    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [BW-1:0]  bus_exp_q[$];
    logic [DW:0]    rd_exp_q[$];
    logic [DW-1:0]  gold [int unsigned];
    logic [DW-1:0]  smem [int unsigned];
    logic           ack_en = 1'b0;
    int             ack_cnt = 0;
    int             done_cnt = 0;
    int             err_cnt = 0;
    logic [AW-1:0]  last_addr = '0;
    logic [2:0]     last_cti = '0;
    logic [DW-1:0]  w_d [8];
    logic [3:0]     w_s [8];

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [2:0]    len;
        logic [AW-1:0] exp_last_addr;
        logic [2:0]    exp_last_cti;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [2:0] exp_cti(input int i, input int len);
        if (len == 0) return 3'b000;
        if (i == len) return 3'b111;
        return 3'b010;
    endfunction

    // ---------------- Wishbone slave model ----------------
    always @(negedge wb_clk_i) begin
        if (wb_bus.wb_cyc_o && wb_bus.wb_stb_o && ack_en && ($urandom_range(0, 2) != 0)) begin
            wb_bus.wb_ack_i = 1'b1;
            wb_bus.wb_dat_i = smem.exists(int'(wb_bus.wb_addr_o)) ? smem[int'(wb_bus.wb_addr_o)] : '0;
        end else begin
            wb_bus.wb_ack_i = 1'b0;
            wb_bus.wb_dat_i = '0;
        end
    end

    // Bus monitor: every acked beat is compared against the expected queue.
    always @(posedge wb_clk_i) begin
        if (!wb_rst_i && wb_bus.wb_ack_i === 1'b1 && wb_bus.wb_cyc_o && wb_bus.wb_stb_o) begin
            logic [BW-1:0] e;
            int unsigned a;
            ack_cnt++;
            last_addr = wb_bus.wb_addr_o;
            last_cti  = wb_bus.wb_cti_o;
            a = int'(wb_bus.wb_addr_o);
            if (wb_bus.wb_we_o)
                smem[a] = merge(smem.exists(a) ? smem[a] : '0, wb_bus.wb_dat_o, wb_bus.wb_sel_o);
            if (bus_exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL bus_unexpected_ack actual_addr=%0h required=none", wb_bus.wb_addr_o);
            end else begin
                e = bus_exp_q.pop_front();
                check("bus_addr", wb_bus.wb_addr_o, e[64:39]);
                check("bus_cti", wb_bus.wb_cti_o, e[38:36]);
                check("bus_we", wb_bus.wb_we_o, e[65]);
                if (e[65]) begin
                    check("bus_wdata", wb_bus.wb_dat_o, e[31:0]);
                    check("bus_sel", wb_bus.wb_sel_o, e[35:32]);
                end
            end
        end
    end

    // Read stream monitor plus pulse counters.
    always @(negedge wb_clk_i) begin
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
        if (rd_valid === 1'b1) begin
            if (rd_exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected actual=%0h required=none", rd_data);
            end else begin
                check("rd_word", {rd_last, rd_data}, rd_exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_word(input logic [DW-1:0] d, input logic [3:0] s);
        @(negedge wb_clk_i);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_sel   = s;
        @(posedge wb_clk_i);
        #1 wr_valid = 1'b0;
    endtask

    task automatic gen_words(input int len);
        for (int i = 0; i <= len; i++) begin
            w_d[i] = $urandom();
            w_s[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'hF;
        end
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) push_word(w_d[i], w_s[i]);
    endtask

    task automatic issue_cmd(input logic we, input logic [AW-1:0] addr, input logic [2:0] len);
        int t;
        t = 0;
        @(negedge wb_clk_i);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = len;
        while (!cmd_ready && t < 100) begin
            @(negedge wb_clk_i);
            t++;
        end
        check("cmd_accept", cmd_ready, 1'b1);
        @(posedge wb_clk_i);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic queue_write_exp(input logic [AW-1:0] addr, input int len, input logic upd_gold);
        for (int i = 0; i <= len; i++) begin
            logic [AW-1:0] a;
            a = addr + AW'(4 * i);
            bus_exp_q.push_back({1'b1, a, exp_cti(i, len), w_s[i], w_d[i]});
            if (upd_gold)
                gold[int'(a)] = merge(gold.exists(int'(a)) ? gold[int'(a)] : '0, w_d[i], w_s[i]);
        end
    endtask

    task automatic wait_done(input logic is_read);
        int t;
        t = 0;
        @(negedge wb_clk_i);
        while (!done && t < 400) begin
            @(negedge wb_clk_i);
            t++;
        end
        check("done_seen", done, 1'b1);
        if (done) begin
            check("done_cyc", wb_bus.wb_cyc_o, 1'b0);
            check("done_stb", wb_bus.wb_stb_o, 1'b0);
            check("done_we", wb_bus.wb_we_o, 1'b0);
            check("done_cti", wb_bus.wb_cti_o, 3'b000);
            check("done_cmd_ready", cmd_ready, 1'b1);
            check("done_busy", busy, 1'b0);
            if (is_read) check("done_rd_last", rd_last, 1'b1);
            @(negedge wb_clk_i);
            check("done_single", done, 1'b0);
        end
    endtask

    task automatic launch_write(input logic [AW-1:0] addr, input int len);
        queue_write_exp(addr, len, 1'b1);
        issue_cmd(1'b1, addr, 3'(len));
        wait_done(1'b0);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int len);
        for (int i = 0; i <= len; i++) begin
            logic [AW-1:0] a;
            a = addr + AW'(4 * i);
            bus_exp_q.push_back({1'b0, a, exp_cti(i, len), 4'h0, 32'h0});
            rd_exp_q.push_back({(i == len), gold.exists(int'(a)) ? gold[int'(a)] : 32'h0});
        end
        issue_cmd(1'b0, addr, 3'(len));
        wait_done(1'b1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int t;
        int c;
        int d0;
        int e0;
        int a0;

        vecs[0] = '{1'b1, 26'h100,     3'd3, 26'h10C, 3'b111};
        vecs[1] = '{1'b0, 26'h100,     3'd3, 26'h10C, 3'b111};
        vecs[2] = '{1'b1, 26'h040,     3'd0, 26'h040, 3'b000};
        vecs[3] = '{1'b0, 26'h040,     3'd0, 26'h040, 3'b000};
        vecs[4] = '{1'b1, 26'h3FFFFF8, 3'd3, 26'h004, 3'b111};
        vecs[5] = '{1'b0, 26'h3FFFFF8, 3'd3, 26'h004, 3'b111};
        vecs[6] = '{1'b1, 26'h200,     3'd7, 26'h21C, 3'b111};
        vecs[7] = '{1'b0, 26'h200,     3'd7, 26'h21C, 3'b111};
        vecs[8] = '{1'b1, 26'h300,     3'd1, 26'h304, 3'b111};
        vecs[9] = '{1'b0, 26'h300,     3'd1, 26'h304, 3'b111};

        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_wr_ready", wr_ready, 1'b1);
        check("rst_cyc", wb_bus.wb_cyc_o, 1'b0);
        check("rst_stb", wb_bus.wb_stb_o, 1'b0);
        check("rst_cti", wb_bus.wb_cti_o, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_state", state_dbg, IDLE);
        ack_en = 1'b1;

        // Table of bursts: writes followed by read-back of the same region.
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].we) begin
                gen_words(int'(vecs[v].len));
                push_words(int'(vecs[v].len) + 1);
                launch_write(vecs[v].addr, int'(vecs[v].len));
            end else begin
                do_read(vecs[v].addr, int'(vecs[v].len));
            end
            check("vec_last_addr", last_addr, vecs[v].exp_last_addr);
            check("vec_last_cti", last_cti, vecs[v].exp_last_cti);
        end

        // Write issued with only two of eight words buffered.
        gen_words(7);
        push_words(2);
        queue_write_exp(26'h500, 7, 1'b1);
        issue_cmd(1'b1, 26'h500, 3'd7);
        repeat (4) begin
            @(negedge wb_clk_i);
            check("stall_state", state_dbg, WAIT_DATA);
            check("stall_cyc", wb_bus.wb_cyc_o, 1'b0);
        end
        for (int i = 2; i < 8; i++) push_word(w_d[i], w_s[i]);
        @(negedge wb_clk_i);
        check("stall_cyc_after_push", wb_bus.wb_cyc_o, 1'b0);
        @(negedge wb_clk_i);
        check("stall_cyc_rise", wb_bus.wb_cyc_o, 1'b1);
        wait_done(1'b0);
        do_read(26'h500, 7);

        // Read timeout: slave silent.
        ack_en = 1'b0;
        d0 = done_cnt;
        e0 = err_cnt;
        issue_cmd(1'b0, 26'h600, 3'd2);
        t = 0;
        @(negedge wb_clk_i);
        while (!wb_bus.wb_cyc_o && t < 20) begin
            @(negedge wb_clk_i);
            t++;
        end
        c = 0;
        while (wb_bus.wb_cyc_o && c < 100) begin
            @(negedge wb_clk_i);
            c++;
        end
        check("tmo_cycles", c, 16);
        check("tmo_err", err, 1'b1);
        check("tmo_busy_abort", busy, 1'b1);
        check("tmo_state", state_dbg, ABORT);
        @(negedge wb_clk_i);
        check("tmo_busy_after", busy, 1'b0);
        check("tmo_err_single", err, 1'b0);
        check("tmo_err_count", err_cnt, e0 + 1);
        check("tmo_no_done", done_cnt, d0);

        // Write timeout must flush its buffered beats.
        gen_words(3);
        push_words(4);
        issue_cmd(1'b1, 26'h680, 3'd3);
        t = 0;
        while (!err && t < 100) begin
            @(negedge wb_clk_i);
            t++;
        end
        check("wtmo_err", err, 1'b1);
        @(negedge wb_clk_i);
        check("wtmo_idle", busy, 1'b0);

        // Fill the FIFO to full and try one extra push.
        gen_words(7);
        for (int i = 0; i < 8; i++) begin
            @(negedge wb_clk_i);
            check("fill_wr_ready", wr_ready, 1'b1);
            push_word(w_d[i], w_s[i]);
        end
        @(negedge wb_clk_i);
        check("full_wr_ready", wr_ready, 1'b0);
        push_word(32'hDEAD_BEEF, 4'hF);
        @(negedge wb_clk_i);
        check("full_still", wr_ready, 1'b0);
        ack_en = 1'b1;
        launch_write(26'h700, 7);
        do_read(26'h700, 7);

        // Reset during beat two of an eight-beat write.
        gen_words(7);
        push_words(8);
        queue_write_exp(26'h800, 7, 1'b0);
        issue_cmd(1'b1, 26'h800, 3'd7);
        a0 = ack_cnt;
        t = 0;
        @(negedge wb_clk_i);
        while (ack_cnt < a0 + 1 && t < 200) begin
            @(negedge wb_clk_i);
            t++;
        end
        check("rst_mid_beat1_seen", (ack_cnt >= a0 + 1), 1'b1);
        d0 = done_cnt;
        e0 = err_cnt;
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        check("rst_mid_cyc", wb_bus.wb_cyc_o, 1'b0);
        check("rst_mid_stb", wb_bus.wb_stb_o, 1'b0);
        check("rst_mid_wr_ready", wr_ready, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        wb_rst_i = 1'b0;
        bus_exp_q.delete();
        repeat (3) @(negedge wb_clk_i);
        check("rst_mid_no_done", done_cnt, d0);
        check("rst_mid_no_err", err_cnt, e0);
        gen_words(3);
        push_words(4);
        launch_write(26'h900, 3);
        do_read(26'h900, 3);

        repeat (3) @(negedge wb_clk_i);
        check("bus_queue_empty", bus_exp_q.size(), 0);
        check("rd_queue_empty", rd_exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
